eval_arbiter: RTL and testbench

EVAL_ARBITER -- requirements
Module: eval_arbiter

---
 rtl/eval_arbiter_pkg.sv | 14 +
 rtl/eval_arbiter_func_eval.sv | 30 +++
 rtl/eval_arbiter.sv | 110 +++++++++++
 tb/tb_eval_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/eval_arbiter_pkg.sv
// Shared types and constants for the round-robin function-evaluator arbiter.
package eval_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int X_W   = 5;
    localparam logic [31:0] F_TABLE = 32'h81E855AC;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

endpackage

// File: rtl/eval_arbiter_func_eval.sv
// Combinational 5-input function: 2:4 decode of {x4,x3} feeding an 8:1 mux on x[2:0].
module func_eval
    import eval_arbiter_pkg::*;
(
    input  logic [X_W-1:0] x,
    output logic           y
);

    logic [3:0] dec;

    // dec[0]: ~x4&~x3, dec[1]: ~x4&x3, dec[2]: x4&~x3, dec[3]: x4&x3
    always_comb begin
        dec = 4'b0001 << x[4:3];
    end

    always_comb begin
        y = 1'b0;
        case (x[2:0])
            3'd0:    y = dec[1] | dec[3];
            3'd1:    y = 1'b0;
            3'd2:    y = dec[0] | dec[1];
            3'd3:    y = dec[0] | dec[2];
            3'd4:    y = dec[1];
            3'd5:    y = dec[0] | dec[2];
            3'd6:    y = dec[1] | dec[2];
            default: y = dec[0] | dec[2] | dec[3];
        endcase
    end

endmodule

// File: rtl/eval_arbiter.sv
// Round-robin arbiter sharing one function evaluator between requesters and a background truth-table sweep.
module eval_arbiter #(
    parameter int N_REQ = eval_arbiter_pkg::N_REQ
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_REQ-1:0]                      req,
    input  logic [N_REQ*eval_arbiter_pkg::X_W-1:0] req_x,
    output logic [N_REQ-1:0]                      gnt,
    output logic                                  rsp_valid,
    output logic [1:0]                            rsp_id,
    output logic                                  rsp_y,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [31:0]                           sweep_table
);
    import eval_arbiter_pkg::*;

    logic [1:0]     last_q;
    logic [1:0]     win;
    logic [1:0]     idx;
    logic           found;
    logic           any_req;
    logic [X_W-1:0] eval_x;
    logic           eval_y;
    state_t         state;
    logic [4:0]     count;

    assign any_req = |req;

    // Search starts one past the last winner; offset N_REQ wraps back onto it.
    always_comb begin
        win   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any_req && !rst) begin
            gnt[win] = 1'b1;
        end
    end

    // Requests always own the evaluator; the sweep only sees it on idle cycles.
    assign eval_x = any_req ? req_x[int'(win)*X_W +: X_W] : count;

    func_eval u_eval (
        .x (eval_x),
        .y (eval_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= 2'(N_REQ - 1);
            rsp_valid   <= 1'b0;
            rsp_id      <= 2'd0;
            rsp_y       <= 1'b0;
            state       <= IDLE;
            count       <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sweep_table <= 32'd0;
        end else begin
            done      <= 1'b0;
            rsp_valid <= any_req;
            if (any_req) begin
                rsp_id <= win;
                rsp_y  <= eval_y;
                last_q <= win;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SWEEP;
                        busy        <= 1'b1;
                        count       <= 5'd0;
                        sweep_table <= 32'd0;
                    end
                end
                SWEEP: begin
                    if (!any_req) begin
                        sweep_table[count] <= eval_y;
                        count              <= count + 5'd1;
                        if (count == 5'd31) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eval_arbiter.sv
// Directed scoreboard bench for eval_arbiter: expected responses queued at grant, popped by a monitor.
module tb_eval_arbiter;
    import eval_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] req_x;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_y;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] sweep_table;

    logic [31:0] ftab = F_TABLE;
    logic [2:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_cycles = 0;
    int          done_count = 0;

    eval_arbiter #(.N_REQ(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_x       (req_x),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_y       (rsp_y),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .sweep_table (sweep_table)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cycles = busy_cycles + 1;
        if (done) done_count = done_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented response must match the oldest queued expectation.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e[2:1]));
                    chk("rsp_y", 32'(rsp_y), 32'(e[0]));
                end
            end
        end
    end

    task automatic cycle(input logic [3:0] r, input logic [19:0] xs, input logic st,
                         input logic [3:0] eg);
        @(posedge clk);
        #1;
        req   = r;
        req_x = xs;
        start = st;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) exp_q.push_back({2'(i), ftab[xs[5*i +: 5]]});
        end
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req   = 4'hF;
        req_x = 20'd0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_table", sweep_table, 32'd0);
        req = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four requesting: x0=2, x1=0, x2=16, x3=7
        for (int r = 0; r < 2; r++) begin
            cycle(4'hF, 20'h3C002, 1'b0, 4'b0001);
            cycle(4'hF, 20'h3C002, 1'b0, 4'b0010);
            cycle(4'hF, 20'h3C002, 1'b0, 4'b0100);
            cycle(4'hF, 20'h3C002, 1'b0, 4'b1000);
        end

        // Single requester 0 with x=2 -> y=1, then outputs hold while idle
        cycle(4'b0001, 20'd2, 1'b0, 4'b0001);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rsp_id_hold", 32'(rsp_id), 32'd0);
        chk("idle_rsp_y_hold", 32'(rsp_y), 32'd1);

        // Uninterrupted sweep
        busy_cycles = 0;
        done_count  = 0;
        cycle(4'b0000, 20'd0, 1'b1, 4'b0000);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        wait_done();
        chk("sweep_busy_cycles", 32'(busy_cycles), 32'd32);
        chk("sweep_table", sweep_table, 32'h81E855AC);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        chk("sweep_done_pulses", 32'(done_count), 32'd1);
        chk("done_width", 32'(done), 32'd0);
        chk("table_held", sweep_table, 32'h81E855AC);

        // Sweep stalled five cycles by requester 2 with x=16 -> y=0
        busy_cycles = 0;
        done_count  = 0;
        cycle(4'b0000, 20'd0, 1'b1, 4'b0000);
        repeat (3) cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        repeat (5) cycle(4'b0100, 20'd16 << 10, 1'b0, 4'b0100);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        wait_done();
        chk("stall_busy_cycles", 32'(busy_cycles), 32'd37);
        chk("stall_table", sweep_table, 32'h81E855AC);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        chk("stall_done_pulses", 32'(done_count), 32'd1);

        // Reset in the cycle where the counter sits at 10
        done_count = 0;
        cycle(4'b0000, 20'd0, 1'b1, 4'b0000);
        repeat (10) cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        chk("midsweep_busy", 32'(busy), 32'd1);
        chk("midsweep_table", sweep_table, 32'h000001AC);
        #1;
        rst = 1'b1;
        req = 4'hF;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_table", sweep_table, 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        req = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        chk("abandon_no_done", 32'(done_count), 32'd0);
        chk("abandon_busy", 32'(busy), 32'd0);

        // Alternating requesters 0 (x=1 -> 0) and 1 (x=31 -> 1); second start ignored
        busy_cycles = 0;
        done_count  = 0;
        cycle(4'b0000, 20'd0, 1'b1, 4'b0000);
        cycle(4'b0011, 20'h003E1, 1'b0, 4'b0001);
        cycle(4'b0011, 20'h003E1, 1'b0, 4'b0010);
        cycle(4'b0011, 20'h003E1, 1'b1, 4'b0001);
        cycle(4'b0011, 20'h003E1, 1'b0, 4'b0010);
        cycle(4'b0011, 20'h003E1, 1'b0, 4'b0001);
        cycle(4'b0011, 20'h003E1, 1'b0, 4'b0010);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        wait_done();
        chk("alt_busy_cycles", 32'(busy_cycles), 32'd38);
        chk("alt_table", sweep_table, 32'h81E855AC);
        cycle(4'b0000, 20'd0, 1'b0, 4'b0000);
        chk("alt_done_pulses", 32'(done_count), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
